// File: rtl/sap_pkg.sv
// Shared SAP definitions: program-loader state encoding used by the loader
// and by the control sequencer that watches it.
package sap_pkg;

    localparam int LOADER_STATE_W = 3;

    typedef enum logic [LOADER_STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/sap_checksum_acc.sv
// DATA_W-bit modular accumulator with synchronous clear and enable.
// Used twice by the loader: once for the sum of words written, once for
// the sum of words read back.
module sap_checksum_acc
    import sap_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] r_sum;

    // Accumulate the incoming word; the adder wraps naturally at DATA_W bits.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_sum <= '0;
        end else if (i_enable) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/sap_program_loader.sv
// Program loader for the SAP CPU: accepts a valid/ready word stream, writes
// it to program RAM from address 0, optionally reads it back to compare
// checksums, and keeps the CPU held in reset until a load completes cleanly.
module sap_program_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int VERIFY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_ld_valid,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_word_count
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

    loader_state_t     r_state;
    loader_state_t     w_nextState;

    logic              r_we;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W:0]   r_wordCount;
    logic [ADDR_W:0]   r_rdAddr;
    logic              r_rdValid;
    logic              r_lastPend;
    logic              r_done;
    logic              r_error;

    logic              w_ldReady;
    logic              w_handshake;
    logic              w_overflow;
    logic              w_accept;
    logic              w_startOk;
    logic              w_rdIssue;
    logic              w_rdAccum;
    logic              w_verifyDone;
    logic              w_sumMatch;
    logic [DATA_W-1:0] w_loadSum;
    logic [DATA_W-1:0] w_readSum;
    logic [DATA_W-1:0] w_readSumNext;

    // The cycle after the final word is accepted is spent issuing its write
    // strobe, so ready drops then even though the state is still LOAD.
    assign w_ldReady    = (r_state == S_LOAD) && !r_lastPend;
    assign w_handshake  = i_ld_valid && w_ldReady;
    assign w_overflow   = w_handshake && (r_wordCount == LP_DEPTH);
    assign w_accept     = w_handshake && !w_overflow;
    assign w_startOk    = i_start &&
                          ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_FAIL));

    // Readback: one address per cycle until all words are issued; data for an
    // address returns one cycle later, and the last return closes the check.
    assign w_rdIssue     = (r_state == S_VERIFY) && (r_rdAddr < r_wordCount);
    assign w_rdAccum     = (r_state == S_VERIFY) && r_rdValid;
    assign w_verifyDone  = w_rdAccum && (r_rdAddr == r_wordCount);
    assign w_readSumNext = w_readSum + i_ram_rdata;
    assign w_sumMatch    = (w_readSumNext == w_loadSum);

    sap_checksum_acc #(.DATA_W(DATA_W)) u_loadSum (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_startOk),
        .i_enable (w_accept),
        .i_data   (i_ld_data),
        .o_sum    (w_loadSum)
    );

    sap_checksum_acc #(.DATA_W(DATA_W)) u_readSum (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_startOk),
        .i_enable (w_rdAccum),
        .i_data   (i_ram_rdata),
        .o_sum    (w_readSum)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: start only from the resting states, leave LOAD once
    // the final write strobe has gone out or on overflow, leave VERIFY on the
    // last returned read word.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_RUN, S_FAIL: begin
                if (i_start) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_lastPend) begin
                    w_nextState = (VERIFY != 0) ? S_VERIFY : S_RUN;
                end else if (w_overflow) begin
                    w_nextState = S_FAIL;
                end
            end
            S_VERIFY: begin
                if (w_verifyDone) begin
                    w_nextState = w_sumMatch ? S_RUN : S_FAIL;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: write strobe/address/data, word counter, readback counter and
    // the sticky done/error flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we        <= 1'b0;
            r_wrAddr    <= '0;
            r_wdata     <= '0;
            r_wordCount <= '0;
            r_rdAddr    <= '0;
            r_rdValid   <= 1'b0;
            r_lastPend  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_rdValid <= w_rdIssue;
            if (w_startOk) begin
                r_wordCount <= '0;
                r_rdAddr    <= '0;
                r_lastPend  <= 1'b0;
                r_done      <= 1'b0;
                r_error     <= 1'b0;
            end
            if (w_accept) begin
                r_we        <= 1'b1;
                r_wrAddr    <= r_wordCount[ADDR_W-1:0];
                r_wdata     <= i_ld_data;
                r_wordCount <= r_wordCount + LP_ONE;
                r_lastPend  <= i_ld_last;
            end
            if (w_overflow) begin
                r_error <= 1'b1;
            end
            if ((r_state == S_LOAD) && r_lastPend) begin
                r_lastPend <= 1'b0;
                if (VERIFY == 0) begin
                    r_done <= 1'b1;
                end
            end
            if (w_rdIssue) begin
                r_rdAddr <= r_rdAddr + LP_ONE;
            end
            if (w_verifyDone) begin
                r_done  <= w_sumMatch;
                r_error <= !w_sumMatch;
            end
        end
    end

    assign o_ld_ready   = w_ldReady;
    assign o_ram_we     = r_we;
    assign o_ram_addr   = (r_state == S_VERIFY) ? r_rdAddr[ADDR_W-1:0] : r_wrAddr;
    assign o_ram_wdata  = r_wdata;
    assign o_cpu_hold   = (r_state != S_RUN);
    assign o_busy       = (r_state == S_LOAD) || (r_state == S_VERIFY);
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_word_count = r_wordCount;

endmodule

// File: tb/tb_sap_program_loader.sv
// Bench for sap_program_loader: one instance with readback verification
// (ADDR_W=4, DATA_W=8) and one without (ADDR_W=8, DATA_W=16). Expected RAM
// writes are queued as words are handed over and popped as strobes appear.
module tb_sap_program_loader;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Instance A: ADDR_W=4, DATA_W=8, VERIFY=1
    logic        aStart, aValid, aLast, aReady, aWe, aHold, aBusy, aDone, aError;
    logic [7:0]  aData, aWdata, aRdata;
    logic [3:0]  aAddr;
    logic [4:0]  aCount;

    // Instance B: ADDR_W=8, DATA_W=16, VERIFY=0
    logic        bStart, bValid, bLast, bReady, bWe, bHold, bBusy, bDone, bError;
    logic [15:0] bData, bWdata, bRdata;
    logic [7:0]  bAddr;
    logic [8:0]  bCount;

    logic [7:0]  memA [16];
    logic        corruptA;
    logic [11:0] expA[$];
    logic [23:0] expB[$];
    logic [7:0]  sentA[$];
    int          wrCountA, wrCountB, nextAddrA, nextAddrB;

    always #5 clk = ~clk;

    sap_program_loader #(.ADDR_W(4), .DATA_W(8), .VERIFY(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(aStart),
        .i_ld_valid(aValid), .i_ld_data(aData), .i_ld_last(aLast), .o_ld_ready(aReady),
        .o_ram_we(aWe), .o_ram_addr(aAddr), .o_ram_wdata(aWdata), .i_ram_rdata(aRdata),
        .o_cpu_hold(aHold), .o_busy(aBusy), .o_done(aDone), .o_error(aError),
        .o_word_count(aCount)
    );

    sap_program_loader #(.ADDR_W(8), .DATA_W(16), .VERIFY(0)) dutB (
        .i_clk(clk), .i_rst(rst), .i_start(bStart),
        .i_ld_valid(bValid), .i_ld_data(bData), .i_ld_last(bLast), .o_ld_ready(bReady),
        .o_ram_we(bWe), .o_ram_addr(bAddr), .o_ram_wdata(bWdata), .i_ram_rdata(bRdata),
        .o_cpu_hold(bHold), .o_busy(bBusy), .o_done(bDone), .o_error(bError),
        .o_word_count(bCount)
    );

    // Program RAM model for A: registered read, optional corruption of address 2.
    always @(posedge clk) begin
        if (aWe) begin
            memA[aAddr] <= (corruptA && (aAddr == 4'd2)) ? 8'hE1 : aWdata;
        end
        aRdata <= memA[aAddr];
    end

    // Write scoreboards: every strobe must match the oldest queued word.
    initial begin
        logic [11:0] ea;
        logic [23:0] eb;
        forever begin
            @(negedge clk);
            if (aWe === 1'b1) begin
                wrCountA++;
                checks++;
                if (expA.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL writeA unexpected strobe addr=%h data=%h required none", aAddr, aWdata);
                end else begin
                    ea = expA.pop_front();
                    if ({aAddr, aWdata} !== ea) begin
                        errors++;
                        $display("[TB] FAIL writeA got addr/data=%h required %h", {aAddr, aWdata}, ea);
                    end
                end
            end
            if (bWe === 1'b1) begin
                wrCountB++;
                checks++;
                if (expB.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL writeB unexpected strobe addr=%h data=%h required none", bAddr, bWdata);
                end else begin
                    eb = expB.pop_front();
                    if ({bAddr, bWdata} !== eb) begin
                        errors++;
                        $display("[TB] FAIL writeB got addr/data=%h required %h", {bAddr, bWdata}, eb);
                    end
                end
            end
        end
    end

    // Safety net against a hung handshake or state machine.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] sum8(input logic [7:0] w[$], input int corruptIdx);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < w.size(); i++) begin
            s = s + ((i == corruptIdx) ? 8'hE1 : w[i]);
        end
        return s;
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAll();
        rst = 1'b1;
        aStart = 0; aValid = 0; aLast = 0; aData = '0;
        bStart = 0; bValid = 0; bLast = 0; bData = '0;
        corruptA = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expA.delete(); expB.delete(); sentA.delete();
        wrCountA = 0; wrCountB = 0; nextAddrA = 0; nextAddrB = 0;
    endtask

    task automatic startA();
        aStart = 1'b1;
        align();
        aStart = 1'b0;
        nextAddrA = 0; wrCountA = 0;
        sentA.delete();
    endtask

    task automatic startB();
        bStart = 1'b1;
        align();
        bStart = 1'b0;
        nextAddrB = 0; wrCountB = 0;
    endtask

    task automatic sendA(input logic [7:0] d, input logic last, input int gap, input logic expectWrite);
        int n;
        repeat (gap) align();
        aValid = 1'b1; aData = d; aLast = last; n = 0;
        @(negedge clk);
        while (aReady !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (aReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL handshakeA timeout ready=%b required 1", aReady);
        end else if (expectWrite) begin
            expA.push_back({nextAddrA[3:0], d});
            nextAddrA++;
            sentA.push_back(d);
        end
        align();
        aValid = 1'b0; aLast = 1'b0;
    endtask

    task automatic sendB(input logic [15:0] d, input logic last);
        int n;
        bValid = 1'b1; bData = d; bLast = last; n = 0;
        @(negedge clk);
        while (bReady !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (bReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL handshakeB timeout ready=%b required 1", bReady);
        end else begin
            expB.push_back({nextAddrB[7:0], d});
            nextAddrB++;
        end
        align();
        bValid = 1'b0; bLast = 1'b0;
    endtask

    // Counts busy cycles and returns at the negedge where busy is first low.
    task automatic waitIdleA(output int n);
        n = 0;
        @(negedge clk);
        while (aBusy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic waitIdleB(output int n);
        n = 0;
        @(negedge clk);
        while (bBusy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetAll();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({aHold, aReady, aWe, aBusy, aDone, aError} !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL reset_flagsA got=%b required 100000", {aHold, aReady, aWe, aBusy, aDone, aError});
        end
        checks++;
        if ({aAddr, aWdata, aCount} !== 17'h0) begin
            errors++;
            $display("[TB] FAIL reset_busA got addr=%h wdata=%h count=%h required 0", aAddr, aWdata, aCount);
        end
        checks++;
        if ({bHold, bReady, bWe, bBusy, bDone, bError, bCount} !== {6'b100000, 9'd0}) begin
            errors++;
            $display("[TB] FAIL reset_B got flags=%b count=%0d required 100000/0",
                     {bHold, bReady, bWe, bBusy, bDone, bError}, bCount);
        end
        align();
        rst = 1'b0;
    endtask

    task automatic test_load_verify();
        int n;
        resetAll();
        startA();
        @(negedge clk);
        checks++;
        if ({aBusy, aReady, aHold, aDone, aError, aCount} !== {5'b11100, 5'd0}) begin
            errors++;
            $display("[TB] FAIL start_load got flags=%b count=%0d required 11100/0",
                     {aBusy, aReady, aHold, aDone, aError}, aCount);
        end
        align();
        sendA(8'h10, 1'b0, 0, 1'b1);
        sendA(8'h2E, 1'b0, 0, 1'b1);
        sendA(8'hE0, 1'b0, 0, 1'b1);
        sendA(8'hF0, 1'b1, 0, 1'b1);
        waitIdleA(n);
        checks++;
        if (n != 6) begin
            errors++;
            $display("[TB] FAIL verify_latency got %0d busy cycles after last required 6", n);
        end
        checks++;
        if ({aDone, aError, aHold, aCount} !== {3'b100, 5'd4}) begin
            errors++;
            $display("[TB] FAIL load_ok got done/err/hold=%b count=%0d required 100/4",
                     {aDone, aError, aHold}, aCount);
        end
        checks++;
        if (wrCountA != 4 || expA.size() != 0) begin
            errors++;
            $display("[TB] FAIL strobesA got %0d left %0d required 4 left 0", wrCountA, expA.size());
        end
        align();
    endtask

    task automatic test_corrupt();
        int n;
        logic expErr;
        resetAll();
        corruptA = 1'b1;
        startA();
        sendA(8'h10, 1'b0, 0, 1'b1);
        sendA(8'h2E, 1'b0, 2, 1'b1);
        sendA(8'hE0, 1'b0, 1, 1'b1);
        sendA(8'hF0, 1'b1, 3, 1'b1);
        expErr = (sum8(sentA, -1) != sum8(sentA, 2));
        waitIdleA(n);
        checks++;
        if (n != 6) begin
            errors++;
            $display("[TB] FAIL corrupt_latency got %0d required 6", n);
        end
        checks++;
        if ({aError, aDone, aHold} !== {expErr, !expErr, 1'b1}) begin
            errors++;
            $display("[TB] FAIL corrupt_result got err/done/hold=%b required %b",
                     {aError, aDone, aHold}, {expErr, !expErr, 1'b1});
        end
        repeat (3) align();
        @(negedge clk);
        checks++;
        if ({aHold, aError, aBusy} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL fail_hold got hold/err/busy=%b required 110", {aHold, aError, aBusy});
        end
        checks++;
        if (wrCountA != 4 || expA.size() != 0) begin
            errors++;
            $display("[TB] FAIL strobes_corrupt got %0d left %0d required 4 left 0", wrCountA, expA.size());
        end
        align();
        corruptA = 1'b0;
    endtask

    task automatic test_overflow();
        int n;
        resetAll();
        startA();
        for (int i = 0; i < 16; i++) begin
            sendA(8'(i * 13 + 5), (i == 15), 0, 1'b1);
        end
        waitIdleA(n);
        checks++;
        if (n != 18 || {aDone, aError} !== 2'b10 || aCount !== 5'd16) begin
            errors++;
            $display("[TB] FAIL full_load got busy=%0d done/err=%b count=%0d required 18/10/16",
                     n, {aDone, aError}, aCount);
        end
        align();
        startA();
        @(negedge clk);
        checks++;
        if ({aHold, aDone, aBusy} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL restart_from_run got hold/done/busy=%b required 101", {aHold, aDone, aBusy});
        end
        align();
        for (int i = 0; i < 16; i++) begin
            sendA(8'(i + 100), 1'b0, 0, 1'b1);
        end
        sendA(8'h77, 1'b0, 0, 1'b0);
        @(negedge clk);
        checks++;
        if ({aError, aDone, aReady, aBusy, aHold, aCount} !== {5'b10001, 5'd16}) begin
            errors++;
            $display("[TB] FAIL overflow got err/done/ready/busy/hold=%b count=%0d required 10001/16",
                     {aError, aDone, aReady, aBusy, aHold}, aCount);
        end
        align();
        aValid = 1'b1;
        aData = 8'h55;
        repeat (3) @(negedge clk);
        checks++;
        if (aReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_after_fail got %b required 0", aReady);
        end
        align();
        aValid = 1'b0;
        checks++;
        if (wrCountA != 16 || expA.size() != 0) begin
            errors++;
            $display("[TB] FAIL strobes_overflow got %0d left %0d required 16 left 0", wrCountA, expA.size());
        end
    endtask

    task automatic test_reset_mid_load();
        resetAll();
        startA();
        sendA(8'hA1, 1'b0, 0, 1'b1);
        sendA(8'hA2, 1'b0, 0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({aBusy, aDone, aHold, aReady, aError, aWe, aCount} !== {6'b001000, 5'd0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_load got busy/done/hold/ready/err/we=%b count=%0d required 001000/0",
                     {aBusy, aDone, aHold, aReady, aError, aWe}, aCount);
        end
        align();
        rst = 1'b0;
        aValid = 1'b1;
        aData = 8'hAA;
        repeat (2) @(negedge clk);
        checks++;
        if (aReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_in_idle got %b required 0", aReady);
        end
        align();
        aValid = 1'b0;
        checks++;
        if (wrCountA != 2 || expA.size() != 0) begin
            errors++;
            $display("[TB] FAIL strobes_reset got %0d left %0d required 2 left 0", wrCountA, expA.size());
        end
    endtask

    task automatic test_start_ignored();
        int n;
        resetAll();
        startA();
        sendA(8'h01, 1'b0, 0, 1'b1);
        sendA(8'h02, 1'b0, 0, 1'b1);
        sendA(8'h03, 1'b1, 0, 1'b1);
        aStart = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({aBusy, aCount} !== {1'b1, 5'd3}) begin
                errors++;
                $display("[TB] FAIL start_in_busy cycle %0d got busy=%b count=%0d required 1/3", k, aBusy, aCount);
            end
            align();
        end
        aStart = 1'b0;
        waitIdleA(n);
        checks++;
        if (n != 2 || {aDone, aError, aHold} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL start_ignored_end got busy=%0d done/err/hold=%b required 2/100",
                     n, {aDone, aError, aHold});
        end
        align();
    endtask

    task automatic test_no_verify();
        int n;
        resetAll();
        startB();
        sendB(16'hFFFF, 1'b0);
        bStart = 1'b1;
        align();
        bStart = 1'b0;
        @(negedge clk);
        checks++;
        if ({bBusy, bCount} !== {1'b1, 9'd1}) begin
            errors++;
            $display("[TB] FAIL startB_in_load got busy=%b count=%0d required 1/1", bBusy, bCount);
        end
        align();
        sendB(16'h0001, 1'b0);
        sendB(16'h1234, 1'b1);
        waitIdleB(n);
        checks++;
        if (n != 1 || {bDone, bError, bHold} !== 3'b100 || bCount !== 9'd3) begin
            errors++;
            $display("[TB] FAIL no_verify_run got busy=%0d done/err/hold=%b count=%0d required 1/100/3",
                     n, {bDone, bError, bHold}, bCount);
        end
        checks++;
        if (wrCountB != 3 || expB.size() != 0) begin
            errors++;
            $display("[TB] FAIL strobesB got %0d left %0d required 3 left 0", wrCountB, expB.size());
        end
        align();
        startB();
        @(negedge clk);
        checks++;
        if ({bHold, bDone, bBusy, bCount} !== {3'b101, 9'd0}) begin
            errors++;
            $display("[TB] FAIL startB_in_run got hold/done/busy=%b count=%0d required 101/0",
                     {bHold, bDone, bBusy}, bCount);
        end
        align();
    endtask

    initial begin
        $display("[TB] sap_program_loader bench starting");
        test_reset();
        test_load_verify();
        test_corrupt();
        test_overflow();
        test_reset_mid_load();
        test_start_ignored();
        test_no_verify();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
